// File: rtl/itf_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : itf_port_arbiter_pkg                                         |
// | Description : Shared definitions for the off-chip interface port arbiter:  |
// |               FSM state encoding and command beat field offsets.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package itf_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_XFER = 2'd2,
    ST_FNH  = 2'd3
  } arb_state_e;

  // Command beat layout: {ReqNum, Addr, RdGLB}, LSB first.
  localparam int RDGLB_BIT = 0;
  localparam int ADDR_LSB  = 1;

  // The request count field sits directly above the address field.
  function automatic int reqnum_lsb(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/itf_max_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : itf_max_sel                                                  |
// | Description : Combinational maximum selector over NUM packed values.       |
// |               Ties resolve to the lowest index.                            |
// | Ports       : i_vals - NUM values of W bits, value p at [p*W +: W]         |
// |               o_idx  - index of the (first) maximum value                  |
// |               o_val  - the maximum value                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module itf_max_sel
  import itf_port_arbiter_pkg::*;
#(
  parameter int NUM   = 5,
  parameter int W     = 16,
  parameter int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic [NUM*W-1:0] i_vals,
  output logic [IDX_W-1:0] o_idx,
  output logic [W-1:0]     o_val
);

  always_comb begin
    o_idx = '0;
    o_val = i_vals[W-1:0];
    // Strict greater-than keeps the earliest index on a tie.
    for (int p = 1; p < NUM; p++) begin
      if (i_vals[p*W +: W] > o_val) begin
        o_idx = IDX_W'(p);
        o_val = i_vals[p*W +: W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/itf_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : itf_port_arbiter                                             |
// | Description : Schedules the shared PAD link among GLB write ports          |
// |               (0..NUM_WRPORT-1) and GLB read ports (remaining indices).    |
// |               Urgent ports (EmptyFull or aged out) are served round-robin, |
// |               otherwise the port with the largest pending count wins.      |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               ArbEn               - permit new arbitration                 |
// |               GLBITF_EmptyFull    - per-port urgent flag                   |
// |               GLBITF_ReqNum/Addr  - per-port pending count / offset        |
// |               CCUITF_BaseAddr     - per-port base address                  |
// |               CmdDat/CmdVld/CmdRdy- command beat handshake toward PAD      |
// |               GntPort/GntVld/GntRdGLB - grant to the datapath              |
// |               XferDone            - last beat of granted transfer          |
// |               Busy                - arbiter not idle                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module itf_port_arbiter
  import itf_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int PORT_WIDTH  = 128,
  parameter int NUM_RDPORT  = 2,
  parameter int NUM_WRPORT  = 3,
  parameter int AGE_WIDTH   = 4,
  parameter int AGE_LIMIT   = 8,
  localparam int NUM_PORT   = NUM_RDPORT + NUM_WRPORT,
  localparam int IDX_W      = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ArbEn,
  input  logic [NUM_PORT-1:0]            GLBITF_EmptyFull,
  input  logic [ADDR_WIDTH*NUM_PORT-1:0] GLBITF_ReqNum,
  input  logic [ADDR_WIDTH*NUM_PORT-1:0] GLBITF_Addr,
  input  logic [ADDR_WIDTH*NUM_PORT-1:0] CCUITF_BaseAddr,
  output logic [PORT_WIDTH-1:0]          CmdDat,
  output logic                           CmdVld,
  input  logic                           CmdRdy,
  output logic [IDX_W-1:0]               GntPort,
  output logic                           GntVld,
  output logic                           GntRdGLB,
  input  logic                           XferDone,
  output logic                           Busy
);

  localparam int REQNUM_LSB = reqnum_lsb(ADDR_WIDTH);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       gnt_port_q, gnt_port_d;
  logic [ADDR_WIDTH-1:0]  req_num_q, req_num_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   rd_glb_q, rd_glb_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [AGE_WIDTH-1:0]   age_q [NUM_PORT];
  logic [AGE_WIDTH-1:0]   age_d [NUM_PORT];

  logic [ADDR_WIDTH-1:0]  w_req  [NUM_PORT];
  logic [ADDR_WIDTH-1:0]  w_addr [NUM_PORT];
  logic [ADDR_WIDTH-1:0]  w_base [NUM_PORT];
  logic [NUM_PORT-1:0]    w_cand;
  logic [NUM_PORT-1:0]    w_urgent;

  logic                   w_urg_found;
  logic [IDX_W-1:0]       w_urg_idx;
  logic [IDX_W-1:0]       w_max_idx;
  logic [ADDR_WIDTH-1:0]  w_max_val;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [ADDR_WIDTH-1:0]  w_sel_req;

  generate
    for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
      assign w_req[p]    = GLBITF_ReqNum[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_addr[p]   = GLBITF_Addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_base[p]   = CCUITF_BaseAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      // A port with nothing pending is never granted, even if flagged.
      assign w_cand[p]   = |w_req[p];
      assign w_urgent[p] = w_cand[p] &&
                           (GLBITF_EmptyFull[p] || (age_q[p] >= AGE_WIDTH'(AGE_LIMIT)));
    end
  endgenerate

  // First urgent candidate scanning from the round-robin pointer.
  always_comb begin
    int idx;
    w_urg_found = 1'b0;
    w_urg_idx   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      if (!w_urg_found && w_urgent[idx]) begin
        w_urg_found = 1'b1;
        w_urg_idx   = IDX_W'(idx);
      end
    end
  end

  itf_max_sel #(
    .NUM   (NUM_PORT),
    .W     (ADDR_WIDTH),
    .IDX_W (IDX_W)
  ) u_max_sel (
    .i_vals (GLBITF_ReqNum),
    .o_idx  (w_max_idx),
    .o_val  (w_max_val)
  );

  assign w_sel_idx = w_urg_found ? w_urg_idx : w_max_idx;
  assign w_sel_req = w_urg_found ? w_req[w_urg_idx] : w_max_val;

  always_comb begin
    state_d    = state_q;
    gnt_port_d = gnt_port_q;
    req_num_d  = req_num_q;
    addr_d     = addr_q;
    rd_glb_d   = rd_glb_q;
    rr_ptr_d   = rr_ptr_q;
    age_d      = age_q;
    case (state_q)
      ST_IDLE: begin
        if (ArbEn && (|w_cand)) begin
          state_d    = ST_CMD;
          gnt_port_d = w_sel_idx;
          req_num_d  = w_sel_req;
          // Truncating add: wraps modulo 2^ADDR_WIDTH.
          addr_d     = w_base[w_sel_idx] + w_addr[w_sel_idx];
          rd_glb_d   = (int'(w_sel_idx) >= NUM_WRPORT);
        end
      end
      ST_CMD: begin
        if (CmdRdy) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (XferDone) state_d = ST_FNH;
      end
      ST_FNH: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (int'(gnt_port_q) == NUM_PORT - 1) ? '0 : gnt_port_q + 1'b1;
        for (int p = 0; p < NUM_PORT; p++) begin
          if (IDX_W'(p) == gnt_port_q || !w_cand[p]) begin
            age_d[p] = '0;
          end else if (age_q[p] != '1) begin
            age_d[p] = age_q[p] + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_port_q <= '0;
      req_num_q  <= '0;
      addr_q     <= '0;
      rd_glb_q   <= 1'b0;
      rr_ptr_q   <= '0;
      for (int p = 0; p < NUM_PORT; p++) age_q[p] <= '0;
    end else begin
      state_q    <= state_d;
      gnt_port_q <= gnt_port_d;
      req_num_q  <= req_num_d;
      addr_q     <= addr_d;
      rd_glb_q   <= rd_glb_d;
      rr_ptr_q   <= rr_ptr_d;
      age_q      <= age_d;
    end
  end

  // Command fields come from registers captured at grant time, so the beat
  // is immune to input changes while backpressured.
  always_comb begin
    CmdDat = '0;
    if (state_q == ST_CMD) begin
      CmdDat[RDGLB_BIT]                   = rd_glb_q;
      CmdDat[ADDR_LSB +: ADDR_WIDTH]      = addr_q;
      CmdDat[REQNUM_LSB +: ADDR_WIDTH]    = req_num_q;
    end
  end

  assign CmdVld   = (state_q == ST_CMD);
  assign GntVld   = (state_q == ST_XFER);
  assign Busy     = (state_q != ST_IDLE);
  assign GntPort  = gnt_port_q;
  assign GntRdGLB = rd_glb_q;

endmodule
`default_nettype wire

// File: tb/tb_itf_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_itf_port_arbiter                                          |
// | Description : Directed self-checking bench for itf_port_arbiter.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_itf_port_arbiter;

  localparam int AW = 16;
  localparam int PW = 128;
  localparam int NP = 5;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [NP-1:0]   empty_full;
  logic [AW*NP-1:0] req_num;
  logic [AW*NP-1:0] addr;
  logic [AW*NP-1:0] base;
  logic [PW-1:0]   cmd_dat;
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [IW-1:0]   gnt_port;
  logic            gnt_vld;
  logic            gnt_rd;
  logic            xfer_done;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  itf_port_arbiter #(
    .ADDR_WIDTH (16),
    .PORT_WIDTH (128),
    .NUM_RDPORT (2),
    .NUM_WRPORT (3),
    .AGE_WIDTH  (4),
    .AGE_LIMIT  (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ArbEn            (arb_en),
    .GLBITF_EmptyFull (empty_full),
    .GLBITF_ReqNum    (req_num),
    .GLBITF_Addr      (addr),
    .CCUITF_BaseAddr  (base),
    .CmdDat           (cmd_dat),
    .CmdVld           (cmd_vld),
    .CmdRdy           (cmd_rdy),
    .GntPort          (gnt_port),
    .GntVld           (gnt_vld),
    .GntRdGLB         (gnt_rd),
    .XferDone         (xfer_done),
    .Busy             (busy)
  );

  task automatic clear_ports();
    empty_full = '0;
    req_num    = '0;
    addr       = '0;
    base       = '0;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] rq, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic ef);
    req_num[p*AW +: AW] = rq;
    addr[p*AW +: AW]    = a;
    base[p*AW +: AW]    = b;
    empty_full[p]       = ef;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    arb_en    = 1'b0;
    cmd_rdy   = 1'b1;
    xfer_done = 1'b0;
    clear_ports();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for a command (bounded), then runs one transfer with CmdRdy=1.
  // Returns port=-1 on timeout. Ends in FNH, #1 after the XferDone edge.
  task automatic run_xfer(output int port, output logic [PW-1:0] dat, output int waited);
    port   = -1;
    dat    = '0;
    waited = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cmd_vld) begin
        waited = n;
        break;
      end
    end
    if (waited == 0) return;
    port = int'(gnt_port);
    dat  = cmd_dat;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1 xfer_done = 1'b1;
    @(posedge clk);
    #1 xfer_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (cmd_vld !== 1'b0 || gnt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b%0b exp=00", cmd_vld, gnt_vld); end
    checks++; if (cmd_dat !== '0) begin failures++; $display("FAIL reset_cmddat got=%0h exp=0", cmd_dat); end
    checks++; if (gnt_port !== '0 || gnt_rd !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%0d/%0b exp=0/0", gnt_port, gnt_rd); end
    // Flagged ports with nothing pending must never be granted.
    empty_full = '1;
    arb_en     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_req_busy got=%0b exp=0", busy); end
    arb_en = 1'b0;
  endtask

  task automatic test_urgent_rr();
    int exp_port [4] = '{1, 3, 1, 3};
    int p, w;
    logic [PW-1:0] d, exp_dat;
    do_reset();
    set_port(1, 16'd4, 16'h0005, 16'h0100, 1'b1);
    set_port(3, 16'd4, 16'h0007, 16'h0300, 1'b1);
    arb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_xfer(p, d, w);
      exp_dat = (exp_port[i] == 1) ? 128'h8020A : 128'h8060F;
      checks++; if (p !== exp_port[i]) begin failures++; $display("FAIL rr_port[%0d] got=%0d exp=%0d", i, p, exp_port[i]); end
      checks++; if (d !== exp_dat) begin failures++; $display("FAIL rr_cmddat[%0d] got=%0h exp=%0h", i, d, exp_dat); end
      if (i > 0) begin
        checks++; if (w !== 2) begin failures++; $display("FAIL rr_gap[%0d] got=%0d exp=2", i, w); end
      end
    end
    arb_en = 1'b0;
  endtask

  task automatic test_max_tie();
    int p, w;
    logic [PW-1:0] d;
    do_reset();
    set_port(0, 16'd10, 16'h0000, 16'h0000, 1'b0);
    set_port(1, 16'd40, 16'h0040, 16'h0000, 1'b0);
    set_port(2, 16'd40, 16'h0000, 16'h0000, 1'b0);
    set_port(3, 16'd5,  16'h0000, 16'h0000, 1'b0);
    arb_en = 1'b1;
    run_xfer(p, d, w);
    arb_en = 1'b0;
    checks++; if (p !== 1) begin failures++; $display("FAIL max_port got=%0d exp=1", p); end
    checks++; if (d[32:17] !== 16'd40) begin failures++; $display("FAIL max_reqnum got=%0d exp=40", d[32:17]); end
    checks++; if (d !== 128'h500080) begin failures++; $display("FAIL max_cmddat got=%0h exp=500080", d); end
  endtask

  task automatic test_addr_wrap();
    int p, w;
    logic [PW-1:0] d;
    do_reset();
    set_port(4, 16'd2, 16'h0020, 16'hFFF0, 1'b1);
    arb_en = 1'b1;
    run_xfer(p, d, w);
    arb_en = 1'b0;
    checks++; if (p !== 4) begin failures++; $display("FAIL wrap_port got=%0d exp=4", p); end
    checks++; if (d[16:1] !== 16'h0010) begin failures++; $display("FAIL wrap_addr got=%0h exp=0010", d[16:1]); end
    checks++; if (d !== 128'h40021) begin failures++; $display("FAIL wrap_cmddat got=%0h exp=40021", d); end
    checks++; if (gnt_rd !== 1'b1) begin failures++; $display("FAIL wrap_rdglb got=%0b exp=1", gnt_rd); end
  endtask

  task automatic test_backpressure();
    int waited;
    do_reset();
    set_port(2, 16'd7, 16'h0234, 16'h1000, 1'b0);
    cmd_rdy = 1'b0;
    arb_en  = 1'b1;
    waited  = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cmd_vld) begin waited = n; break; end
    end
    checks++; if (waited == 0) begin failures++; $display("FAIL bp_timeout got=none exp=CmdVld"); end
    checks++; if (cmd_dat !== 128'hE2468 || gnt_port !== 3'd2) begin failures++; $display("FAIL bp_cmd got=%0h/%0d exp=e2468/2", cmd_dat, gnt_port); end
    for (int i = 0; i < 5; i++) begin
      empty_full = NP'($urandom);
      req_num    = (AW*NP)'({$urandom, $urandom, $urandom});
      addr       = (AW*NP)'({$urandom, $urandom, $urandom});
      base       = (AW*NP)'({$urandom, $urandom, $urandom});
      @(posedge clk); #1;
      checks++; if (cmd_vld !== 1'b1 || cmd_dat !== 128'hE2468) begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%0h exp=1/e2468", i, cmd_vld, cmd_dat); end
    end
    cmd_rdy = 1'b1;
    arb_en  = 1'b0;
    clear_ports();
    @(posedge clk); #1;
    checks++; if (gnt_vld !== 1'b1 || cmd_vld !== 1'b0) begin failures++; $display("FAIL bp_xfer got=%0b/%0b exp=1/0", gnt_vld, cmd_vld); end
    xfer_done = 1'b1;
    @(posedge clk); #1 xfer_done = 1'b0;
    checks++; if (gnt_port !== 3'd2 || busy !== 1'b1) begin failures++; $display("FAIL bp_fnh got=%0d/%0b exp=2/1", gnt_port, busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_park got=%0b exp=0", busy); end
  endtask

  task automatic test_aging();
    int exp_port [4] = '{2, 2, 2, 0};
    int p, w;
    logic [PW-1:0] d;
    do_reset();
    set_port(0, 16'd1,   16'h0000, 16'h0000, 1'b0);
    set_port(2, 16'd100, 16'h0000, 16'h0000, 1'b0);
    arb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_xfer(p, d, w);
      checks++; if (p !== exp_port[i]) begin failures++; $display("FAIL age_port[%0d] got=%0d exp=%0d", i, p, exp_port[i]); end
    end
    arb_en = 1'b0;
  endtask

  task automatic test_reset_in_xfer();
    int p, w;
    logic [PW-1:0] d;
    do_reset();
    set_port(0, 16'd3, 16'h0000, 16'h0000, 1'b1);
    set_port(2, 16'd3, 16'h0000, 16'h0000, 1'b1);
    arb_en = 1'b1;
    run_xfer(p, d, w);
    checks++; if (p !== 0) begin failures++; $display("FAIL rx_first got=%0d exp=0", p); end
    w = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cmd_vld) begin w = n; break; end
    end
    checks++; if (w == 0 || gnt_port !== 3'd2) begin failures++; $display("FAIL rx_second got=%0d exp=2", gnt_port); end
    @(posedge clk); #1;
    checks++; if (gnt_vld !== 1'b1) begin failures++; $display("FAIL rx_in_xfer got=%0b exp=1", gnt_vld); end
    rst    = 1'b1;
    arb_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (busy !== 1'b0 || gnt_vld !== 1'b0 || cmd_vld !== 1'b0) begin failures++; $display("FAIL rx_after got=%0b%0b%0b exp=000", busy, gnt_vld, cmd_vld); end
    checks++; if (gnt_port !== '0 || cmd_dat !== '0) begin failures++; $display("FAIL rx_regs got=%0d/%0h exp=0/0", gnt_port, cmd_dat); end
    xfer_done = 1'b1;
    @(posedge clk); #1 xfer_done = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rx_done_ignored got=%0b exp=0", busy); end
    arb_en = 1'b1;
    run_xfer(p, d, w);
    arb_en = 1'b0;
    checks++; if (p !== 0) begin failures++; $display("FAIL rx_rrptr got=%0d exp=0", p); end
  endtask

  initial begin
    test_reset();
    test_urgent_rr();
    test_max_tie();
    test_addr_wrap();
    test_backpressure();
    test_aging();
    test_reset_in_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/itf_port_arbiter.md
Name: itf_port_arbiter

Overview:
- Request scheduler in front of the off-chip interface datapath. It shares the single PAD link among the NUM_WRPORT GLB write ports and NUM_RDPORT GLB read ports.
- Each transfer it selects one port, issues one command beat toward the PAD, and holds the grant until the datapath reports the last beat.
- Policy, in priority order:
  - urgent ports (GLB empty/full, or aged out), served round-robin;
  - otherwise the port with the largest pending request count.

Parameters:
- ADDR_WIDTH, 16, width of request count, address, base address.
- PORT_WIDTH, 128, command beat width toward PAD.
- NUM_RDPORT, 2, GLB read ports (data GLB -> PAD).
- NUM_WRPORT, 3, GLB write ports (data PAD -> GLB).
- AGE_WIDTH, 4, per-port age counter width.
- AGE_LIMIT, 8, age at which a pending port becomes urgent; must be <= 2^AGE_WIDTH-1.
- Derived localparam NUM_PORT = NUM_RDPORT+NUM_WRPORT.
- Derived localparam IDX_W = $clog2(NUM_PORT).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ArbEn  in  1  CCU enable; allows new arbitration.
- GLBITF_EmptyFull  in  NUM_PORT  per-port urgent flag.
- GLBITF_ReqNum  in  ADDR_WIDTH*NUM_PORT  per-port pending beat count.
- GLBITF_Addr  in  ADDR_WIDTH*NUM_PORT  per-port offset address.
- CCUITF_BaseAddr  in  ADDR_WIDTH*NUM_PORT  per-port base address.
- CmdDat  out  PORT_WIDTH  command beat.
- CmdVld  out  1  command valid.
- CmdRdy  in  1  PAD accepts command.
- GntPort  out  IDX_W  granted port index.
- GntVld  out  1  grant active, datapath may move data.
- GntRdGLB  out  1  1 = read GLB (to PAD), 0 = write GLB.
- XferDone  in  1  datapath pulse: last beat of granted transfer accepted.
- Busy  out  1  state != IDLE.

Behaviour:
- Port numbering:
  - ports 0..NUM_WRPORT-1 are write-GLB ports, RdGLB=0;
  - ports NUM_WRPORT..NUM_PORT-1 are read-GLB ports, RdGLB=1.
- Candidate port: ReqNum != 0. A port with ReqNum == 0 is never granted, even if EmptyFull=1.
- Urgent candidate: candidate AND (EmptyFull=1 OR age >= AGE_LIMIT).
- Selection (combinational, evaluated in IDLE):
  - If any urgent candidate exists, pick the first urgent candidate scanning RrPtr, RrPtr+1, ... modulo NUM_PORT.
  - Otherwise pick the candidate with the maximum ReqNum; ties go to the lowest index.
- FSM states: IDLE, CMD, XFER, FNH.
- IDLE -> CMD when ArbEn=1 and at least one candidate exists. On this edge, register:
  - GntPort = selected index;
  - ReqNum of that port;
  - Addr = (BaseAddr + Addr) of that port, mod 2^ADDR_WIDTH, wrap with no carry out;
  - RdGLB.
- CMD:
  - CmdVld=1.
  - CmdDat = zero-extended {ReqNum, Addr, RdGLB}, with RdGLB at bit 0, Addr at [ADDR_WIDTH:1], ReqNum above it.
  - CmdDat stays stable while CmdRdy=0, whatever the inputs do.
  - CMD -> XFER on CmdVld & CmdRdy.
- XFER: GntVld=1. XFER -> FNH on XferDone.
- XferDone is ignored in every state other than XFER.
- FNH (one cycle), then -> IDLE:
  - RrPtr = GntPort+1, wrapping to 0 after NUM_PORT-1.
  - Age update:
    - granted port age := 0;
    - a non-granted port with ReqNum != 0 ages +1, saturating at 2^AGE_WIDTH-1;
    - a port with ReqNum == 0 age := 0.
- Minimum inter-grant gap: FNH plus IDLE, i.e. 2 cycles from XferDone to the next CmdVld.
- ArbEn deasserted mid-transfer: the current transfer completes normally; the FSM then parks in IDLE.
- Outputs:
  - CmdVld=1 only in CMD.
  - GntVld=1 only in XFER.
  - GntPort and GntRdGLB hold their registered values from CMD through FNH.
- Reset (rst=1 at clock edge, at any state including mid-CMD or mid-XFER) forces:
  - state IDLE;
  - CmdVld = GntVld = Busy = 0;
  - CmdDat = 0, GntPort = 0, GntRdGLB = 0;
  - RrPtr = 0;
  - all ages 0.
- Reset takes effect on the next edge. No async path.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, CMD=1, XFER=2, FNH=3);
  - command field offsets (RDGLB_BIT=0, ADDR_LSB=1, REQNUM_LSB=ADDR_WIDTH+1).
- One sub-module: itf_max_sel, a parameterised max-value/lowest-index selector over NUM_PORT x ADDR_WIDTH, outputting index and value.
- Round-robin urgent picker and age counters stay inline.

Test Plan:
- Urgent round-robin:
  - Stimulus: ports 1 and 3 EmptyFull=1, ReqNum=4, all others ReqNum=0, XferDone 3 cycles after each grant.
  - Required: grants in order 1, 3, 1, 3; CmdDat[0] is 0 for port 1 and 1 for port 3.
- Max select with tie:
  - Stimulus: ReqNum={10,40,40,5,0}, no urgent.
  - Required: GntPort=1; CmdDat ReqNum field = 40.
- Address wrap:
  - Stimulus: port 4 urgent, BaseAddr=0xFFF0, Addr=0x0020, ReqNum=2.
  - Required: Addr field = 0x0010, RdGLB=1.
- Command backpressure:
  - Stimulus: CmdRdy=0 for 5 cycles while all port inputs change randomly.
  - Required: CmdVld held at 1; CmdDat unchanged; XFER entered the cycle after CmdRdy=1.
- Aging:
  - Stimulus: AGE_LIMIT=3; port 0 ReqNum=1 and port 2 ReqNum=100, both held constant.
  - Required: grants 2, 2, 2, then 0 on the 4th arbitration.
- Reset in XFER:
  - Stimulus: rst=1 for one cycle during XFER.
  - Required: next cycle Busy = GntVld = CmdVld = 0; XferDone afterwards is ignored; next arbitration starts from RrPtr=0.
